// File: rtl/link_fifo_wrapper.sv
// First-word-fall-through FIFO for one directed inter-leaf grid link; 1-cycle push-to-output latency.
// Backpressure: input_ready drops only at DEPTH entries or during reset; no same-cycle push-through when full.
module link_fifo_wrapper #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Outputs depend only on registered state (plus reset on input_ready).
  assign input_ready  = (count != CW'(DEPTH)) && !reset;
  assign output_valid = (count != '0);
  assign output_data  = mem[rd_ptr];

  assign push = input_valid && input_ready;
  assign pop  = output_valid && output_ready;

  // DEPTH is a power of two, so natural AW-bit overflow wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= input_data;
  end

endmodule

// File: tb/tb_link_fifo_wrapper.sv
// Directed bench for link_fifo_wrapper: reset, single word, fill/drain, full+pop, streaming, mid-run reset.
module tb_link_fifo_wrapper;

  localparam int WIDTH = 64;
  localparam int DEPTH = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  link_fifo_wrapper #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    input_data   = '0;
    input_valid  = 1'b0;
    output_ready = 1'b0;

    // Reset held three cycles
    repeat (3) tick();
    chk("rst_ov", 64'(output_valid), 64'd0);
    chk("rst_ir", 64'(input_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_ir", 64'(input_ready), 64'd1);
    chk("rel_ov", 64'(output_valid), 64'd0);

    // Single word, held until consumed
    input_data  = 64'hDEAD_BEEF_0000_0001;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    chk("single_ov", 64'(output_valid), 64'd1);
    chk("single_dat", output_data, 64'hDEAD_BEEF_0000_0001);
    repeat (3) tick();
    chk("hold_ov", 64'(output_valid), 64'd1);
    chk("hold_dat", output_data, 64'hDEAD_BEEF_0000_0001);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("single_empty", 64'(output_valid), 64'd0);

    // Fill to DEPTH, extra write ignored, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_ir", 64'(input_ready), 64'd1);
      input_data  = 64'(i);
      input_valid = 1'b1;
      tick();
    end
    chk("full_ir", 64'(input_ready), 64'd0);
    chk("full_head", output_data, 64'd0);
    input_data = 64'd999;
    tick();
    input_valid = 1'b0;
    chk("overflow_ir", 64'(input_ready), 64'd0);
    output_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_ov", 64'(output_valid), 64'd1);
      chk("drain_dat", output_data, 64'(i));
      tick();
    end
    output_ready = 1'b0;
    chk("drain_empty", 64'(output_valid), 64'd0);

    // Full then a single pop frees exactly one slot, next cycle
    for (int i = 0; i < DEPTH; i++) begin
      input_data  = 64'(i);
      input_valid = 1'b1;
      tick();
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    chk("fp_ir_pop_cycle", 64'(input_ready), 64'd0);
    chk("fp_head", output_data, 64'd0);
    tick();
    output_ready = 1'b0;
    chk("fp_ir_after", 64'(input_ready), 64'd1);
    chk("fp_next_head", output_data, 64'd1);
    input_data  = 64'd128;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    chk("fp_refull_ir", 64'(input_ready), 64'd0);
    output_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("fp_drain_ov", 64'(output_valid), 64'd1);
      chk("fp_drain_dat", output_data, 64'(i));
      tick();
    end
    output_ready = 1'b0;
    chk("fp_empty", 64'(output_valid), 64'd0);

    // Streaming: one word per cycle with a single entry in flight
    input_valid  = 1'b1;
    output_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      input_data = 64'h1000 + 64'(k);
      if (k > 0) begin
        chk("stream_ov", 64'(output_valid), 64'd1);
        chk("stream_ir", 64'(input_ready), 64'd1);
        chk("stream_dat", output_data, 64'h1000 + 64'(k - 1));
      end
      tick();
    end
    input_valid = 1'b0;
    chk("stream_last", output_data, 64'h1000 + 64'd999);
    tick();
    output_ready = 1'b0;
    chk("stream_empty", 64'(output_valid), 64'd0);

    // Mid-operation reset discards queued words
    for (int i = 0; i < 50; i++) begin
      input_data  = 64'hA000 + 64'(i);
      input_valid = 1'b1;
      tick();
    end
    input_valid = 1'b0;
    chk("mid_pre_ov", 64'(output_valid), 64'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ov", 64'(output_valid), 64'd0);
    chk("mid_rst_ir", 64'(input_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rel_ir", 64'(input_ready), 64'd1);
    input_data  = 64'h5;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    chk("mid_first_ov", 64'(output_valid), 64'd1);
    chk("mid_first_dat", output_data, 64'h5);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("mid_empty", 64'(output_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
